// File: rtl/soc_system_pll_reset_seq_if.sv
// PLL sequencer signal bundle: PLL control/status plus the downstream reset and status outputs.
// The sequencer uses the master view; the PLL/observer side uses the slave view.
interface soc_system_pll_reset_seq_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   ready;
  logic                   fail;
  logic [7:0]             lock_lost_cnt;
  logic [2:0]             state;

  modport master (
    input  pll_locked,
    output pll_rst, domain_rst, ready, fail, lock_lost_cnt, state
  );

  modport slave (
    output pll_locked,
    input  pll_rst, domain_rst, ready, fail, lock_lost_cnt, state
  );
endinterface

// File: rtl/soc_system_pll_reset_seq.sv
// System PLL reset sequencer: pulses the PLL reset, qualifies lock, releases downstream
// domains one at a time and re-resets the PLL on lock loss or relock timeout.
//
// state     | meaning
// PLL_RESET | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | waiting for synced lock, bounded by RELOCK_TIMEOUT
// STABLE    | counting consecutive locked cycles
// RELEASE   | clearing domain resets in ascending order, DOMAIN_STAGGER apart
// RUN       | all domains out of reset, ready high
// FAILED    | retries exhausted, only rst leaves
module soc_system_pll_reset_seq #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1000,
  parameter int RELOCK_TIMEOUT     = 100000,
  parameter int MAX_RETRIES        = 7,
  parameter int NUM_DOMAINS        = 3,
  parameter int DOMAIN_STAGGER     = 8
) (
  input logic                        refclk,
  input logic                        rst,
  soc_system_pll_reset_seq_if.master bus
);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAILED    = 3'd5
  } state_t;

  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B   = (RELOCK_TIMEOUT > DOMAIN_STAGGER) ? RELOCK_TIMEOUT : DOMAIN_STAGGER;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] PRC_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LSC_LAST   = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RT_LAST    = CW'(RELOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] DS_LAST    = CW'(DOMAIN_STAGGER - 1);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [1:0]             sync_q;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic [7:0]             lost_q, lost_d;
  logic                   lk;

  assign lk = sync_q[1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      sync_q    <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync_q    <= {sync_q[0], bus.pll_locked};
      pll_rst_q <= pll_rst_d;
      dom_q     <= dom_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    pll_rst_d = pll_rst_q;
    dom_d     = dom_q;
    ready_d   = ready_q;
    fail_d    = fail_q;
    lost_d    = lost_q;

    case (state_q)
      PLL_RESET: begin
        pll_rst_d = 1'b1;
        dom_d     = '1;
        if (cnt_q == PRC_LAST) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == RT_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + RETRY_ONE;
          if (retry_q == RETRY_LAST) begin
            state_d = FAILED;
            fail_d  = 1'b1;
          end else begin
            state_d   = PLL_RESET;
            pll_rst_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STABLE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == LSC_LAST) begin
          cnt_d = '0;
          dom_d = dom_q << 1;
          // A single domain has nothing to stagger, so it goes straight to RUN.
          if (dom_d == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
            retry_d = '0;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RELEASE, RUN: begin
        if (!lk) begin
          state_d   = PLL_RESET;
          cnt_d     = '0;
          dom_d     = '1;
          ready_d   = 1'b0;
          pll_rst_d = 1'b1;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (state_q == RELEASE) begin
          if (cnt_q == DS_LAST) begin
            cnt_d = '0;
            // Resets clear from bit 0 upward, so shifting in a zero releases the next domain.
            dom_d = dom_q << 1;
            if (dom_d == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      FAILED: begin
        pll_rst_d = 1'b0;
        dom_d     = '1;
        fail_d    = 1'b1;
      end

      default: begin
        state_d   = PLL_RESET;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        dom_d     = '1;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
      end
    endcase
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.domain_rst    = dom_q;
  assign bus.ready         = ready_q;
  assign bus.fail          = fail_q;
  assign bus.lock_lost_cnt = lost_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_soc_system_pll_reset_seq.sv
// Bench for the PLL reset sequencer: directed lock/unlock stimulus pushes expected snapshots
// (tagged with the cycle they apply to) into a queue; a negedge monitor pops and compares.
module tb_soc_system_pll_reset_seq;
  localparam int ND = 3;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  soc_system_pll_reset_seq_if #(.NUM_DOMAINS(ND)) bus_if ();

  soc_system_pll_reset_seq #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .RELOCK_TIMEOUT     (32),
    .MAX_RETRIES        (2),
    .NUM_DOMAINS        (ND),
    .DOMAIN_STAGGER     (2)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus_if)
  );

  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [2:0]    st;
    logic          pr;
    logic [ND-1:0] dom;
    logic          rdy;
    logic          fl;
    logic [7:0]    lost;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_lost    = 0;

  always @(negedge refclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", nm, cyc, e.cyc);
      end else if ({bus_if.state, bus_if.pll_rst, bus_if.domain_rst, bus_if.ready, bus_if.fail,
                    bus_if.lock_lost_cnt} !== {e.st, e.pr, e.dom, e.rdy, e.fl, e.lost}) begin
        miscompares++;
        $display("FAIL %s @%0d: got state=%0d pll_rst=%b domain_rst=%b ready=%b fail=%b lost=%0d; required state=%0d pll_rst=%b domain_rst=%b ready=%b fail=%b lost=%0d",
                 nm, cyc, bus_if.state, bus_if.pll_rst, bus_if.domain_rst, bus_if.ready,
                 bus_if.fail, bus_if.lock_lost_cnt, e.st, e.pr, e.dom, e.rdy, e.fl, e.lost);
      end
    end
  end

  task automatic push(input int c, input logic [2:0] st, input logic pr, input logic [ND-1:0] dom,
                      input logic rdy, input logic fl, input string nm);
    exp_t e;
    e.cyc  = c;
    e.st   = st;
    e.pr   = pr;
    e.dom  = dom;
    e.rdy  = rdy;
    e.fl   = fl;
    e.lost = exp_lost[7:0];
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  task automatic do_reset(output int r);
    int c;
    c        = cyc;
    rst      = 1'b1;
    exp_lost = 0;
    push(c + 1, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "reset_values");
    wait_cyc(c + 1);
    rst = 1'b0;
    r   = c + 1;
  endtask

  task automatic pll_reset_checks(input int r);
    push(r + 3, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "pll_rst_last_cycle");
    push(r + 4, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "wait_lock_entry");
  endtask

  // pll_locked rises at cycle l while already in WAIT_LOCK with synced lock low.
  task automatic lock_seq(input int l);
    push(l + 2,  3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "sync_latency");
    push(l + 3,  3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_entry");
    push(l + 10, 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_last");
    push(l + 11, 3'd3, 1'b0, 3'b110, 1'b0, 1'b0, "release_bit0");
    push(l + 12, 3'd3, 1'b0, 3'b110, 1'b0, 1'b0, "stagger_hold1");
    push(l + 13, 3'd3, 1'b0, 3'b100, 1'b0, 1'b0, "release_bit1");
    push(l + 14, 3'd3, 1'b0, 3'b100, 1'b0, 1'b0, "stagger_hold2");
    push(l + 15, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, "run_entry");
  endtask

  task automatic loss_event(input bit full);
    int d;
    d = cyc;
    push(d + 2, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, "run_before_loss");
    bus_if.pll_locked = 1'b0;
    exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
    push(d + 3, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "lock_loss");
    if (full) begin
      push(d + 6, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "relock_pll_rst_last");
      push(d + 7, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "relock_wait");
    end
    wait_cyc(d + 7);
    bus_if.pll_locked = 1'b1;
    if (full) lock_seq(d + 7);
    else push(d + 22, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, "relock_run");
    wait_cyc(d + 24);
  endtask

  initial begin
    int r, l, x;
    bus_if.pll_locked = 1'b0;
    @(negedge refclk);

    // Normal bring-up.
    do_reset(r);
    pll_reset_checks(r);
    wait_cyc(r + 4);
    bus_if.pll_locked = 1'b1;
    l = cyc;
    lock_seq(l);
    wait_cyc(l + 20);

    // Lock loss from RUN, first with a full sequence check, then up to saturation.
    loss_event(1'b1);
    for (int i = 1; i < 300; i++) loss_event(1'b0);

    // One-cycle lock glitch while in STABLE.
    bus_if.pll_locked = 1'b0;
    do_reset(r);
    pll_reset_checks(r);
    wait_cyc(r + 4);
    bus_if.pll_locked = 1'b1;
    l = cyc;
    push(l + 3, 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_entry2");
    wait_cyc(l + 5);
    bus_if.pll_locked = 1'b0;
    x = l + 5;
    push(x + 2,  3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_before_drop");
    push(x + 3,  3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "stable_drop");
    push(x + 4,  3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_reentry");
    push(x + 11, 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_restart_last");
    push(x + 12, 3'd3, 1'b0, 3'b110, 1'b0, 1'b0, "release_after_restart");
    push(x + 16, 3'd4, 1'b0, 3'b000, 1'b1, 1'b0, "run_after_restart");
    wait_cyc(x + 1);
    bus_if.pll_locked = 1'b1;
    wait_cyc(x + 20);

    // rst in the middle of RELEASE.
    bus_if.pll_locked = 1'b0;
    do_reset(r);
    pll_reset_checks(r);
    wait_cyc(r + 4);
    bus_if.pll_locked = 1'b1;
    l = cyc;
    push(l + 3,  3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "stable_entry3");
    push(l + 11, 3'd3, 1'b0, 3'b110, 1'b0, 1'b0, "release_before_rst");
    wait_cyc(l + 11);
    rst = 1'b1;
    push(l + 12, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "rst_mid_release");
    wait_cyc(l + 12);
    rst = 1'b0;
    r = l + 12;
    push(r + 3, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "post_rst_pll_rst_last");
    push(r + 4, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "post_rst_wait_lock");
    push(r + 5, 3'd2, 1'b0, 3'b111, 1'b0, 1'b0, "post_rst_stable");
    wait_cyc(r + 10);

    // Lock never arrives: two timeouts then FAILED.
    bus_if.pll_locked = 1'b0;
    do_reset(r);
    pll_reset_checks(r);
    push(r + 35, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "timeout1_last");
    push(r + 36, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "retry_pulse");
    push(r + 39, 3'd0, 1'b1, 3'b111, 1'b0, 1'b0, "retry_pulse_last");
    push(r + 40, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "retry_wait_lock");
    push(r + 71, 3'd1, 1'b0, 3'b111, 1'b0, 1'b0, "timeout2_last");
    push(r + 72, 3'd5, 1'b0, 3'b111, 1'b0, 1'b1, "failed_entry");
    wait_cyc(r + 80);
    bus_if.pll_locked = 1'b1;
    push(r + 100, 3'd5, 1'b0, 3'b111, 1'b0, 1'b1, "failed_sticky");
    wait_cyc(r + 100);

    bus_if.pll_locked = 1'b0;
    do_reset(r);
    pll_reset_checks(r);
    wait_cyc(r + 6);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge refclk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
